// File: rtl/ibis_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : ibis_video_timing
// Purpose  : Raster timing controller for the three TMDS encoder channels.
//            Two small state machines walk the horizontal and vertical
//            timing (active / front porch / sync / back porch). During active
//            video, pixels are pulled from an upstream ready/valid source.
//            Each enable cycle produces registered pixel data, data-enable
//            and sync control symbols for the encoders.
// Ports    : clock, reset (async, active-low), enable (pixel-clock enable)
//            pixel_valid/pixel_data/pixel_ready  upstream pixel handshake
//            clear_underflow                     clears sticky underflow
//            out_data0/1/2                       blue/green/red to encoders
//            out_data_enable                     active-video flag
//            out_control0/1/2                    {vsync,hsync} / 0 / 0
//            position_x/position_y               live raster counters
//            frame_start                         registered (0,0) pulse
//            underflow                           sticky starved-pixel flag
// Revision : 1.0  initial release
// ============================================================================
module ibis_video_timing #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int SYNC_POLARITY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        pixel_valid,
  input  logic [23:0] pixel_data,
  output logic        pixel_ready,
  input  logic        clear_underflow,
  output logic [7:0]  out_data0,
  output logic [7:0]  out_data1,
  output logic [7:0]  out_data2,
  output logic        out_data_enable,
  output logic [1:0]  out_control0,
  output logic [1:0]  out_control1,
  output logic [1:0]  out_control2,
  output logic [11:0] position_x,
  output logic [11:0] position_y,
  output logic        frame_start,
  output logic        underflow
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Positions and counters are 12 bits wide, so totals beyond 4096 cannot
  // be represented; zero-length phases would break the state sequencing.
  if (c_H_TOTAL > 4096 || c_V_TOTAL > 4096) begin : g_bad_total
    $error("ibis_video_timing: horizontal or vertical total exceeds 4096");
  end
  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_param
    $error("ibis_video_timing: every timing parameter must be at least 1");
  end

  // Final in-state count for each phase.
  localparam logic [11:0] c_H_ACTIVE_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] c_H_FRONT_LAST  = 12'(H_FRONT - 1);
  localparam logic [11:0] c_H_SYNC_LAST   = 12'(H_SYNC - 1);
  localparam logic [11:0] c_H_BACK_LAST   = 12'(H_BACK - 1);
  localparam logic [11:0] c_V_ACTIVE_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] c_V_FRONT_LAST  = 12'(V_FRONT - 1);
  localparam logic [11:0] c_V_SYNC_LAST   = 12'(V_SYNC - 1);
  localparam logic [11:0] c_V_BACK_LAST   = 12'(V_BACK - 1);

  localparam logic c_POL = (SYNC_POLARITY != 0);
  // Deasserted sync level on both sync bits.
  localparam logic [1:0] c_CTRL_IDLE = {~c_POL, ~c_POL};

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } state_t;

  function automatic state_t next_state(input state_t s);
    case (s)
      ST_ACTIVE: next_state = ST_FRONT;
      ST_FRONT:  next_state = ST_SYNC;
      ST_SYNC:   next_state = ST_BACK;
      default:   next_state = ST_ACTIVE;
    endcase
  endfunction

  function automatic logic [11:0] h_last(input state_t s);
    case (s)
      ST_ACTIVE: h_last = c_H_ACTIVE_LAST;
      ST_FRONT:  h_last = c_H_FRONT_LAST;
      ST_SYNC:   h_last = c_H_SYNC_LAST;
      default:   h_last = c_H_BACK_LAST;
    endcase
  endfunction

  function automatic logic [11:0] v_last(input state_t s);
    case (s)
      ST_ACTIVE: v_last = c_V_ACTIVE_LAST;
      ST_FRONT:  v_last = c_V_FRONT_LAST;
      ST_SYNC:   v_last = c_V_SYNC_LAST;
      default:   v_last = c_V_BACK_LAST;
    endcase
  endfunction

  state_t      h_state_q, h_state_d;
  state_t      v_state_q, v_state_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [11:0] pos_x_q, pos_x_d;
  logic [11:0] pos_y_q, pos_y_d;
  logic [7:0]  data0_q, data0_d;
  logic [7:0]  data1_q, data1_d;
  logic [7:0]  data2_q, data2_d;
  logic        de_q, de_d;
  logic [1:0]  ctrl0_q, ctrl0_d;
  logic        fs_q, fs_d;
  logic        uf_q, uf_d;

  logic w_active;
  logic w_h_last;
  logic w_v_last;
  logic w_line_end;

  assign w_active   = (h_state_q == ST_ACTIVE) && (v_state_q == ST_ACTIVE);
  assign w_h_last   = (h_cnt_q == h_last(h_state_q));
  assign w_v_last   = (v_cnt_q == v_last(v_state_q));
  assign w_line_end = (h_state_q == ST_BACK) && w_h_last;

  assign pixel_ready = enable && w_active;

  always_comb begin
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    de_d      = de_q;
    ctrl0_d   = ctrl0_q;
    fs_d      = fs_q;
    uf_d      = uf_q;

    if (enable) begin
      // Horizontal sequencing
      if (w_h_last) begin
        h_state_d = next_state(h_state_q);
        h_cnt_d   = '0;
      end else begin
        h_cnt_d   = h_cnt_q + 12'd1;
      end

      // Vertical sequencing steps once per line, on the last back-porch pixel
      if (w_line_end) begin
        pos_x_d = '0;
        if (w_v_last) begin
          v_state_d = next_state(v_state_q);
          v_cnt_d   = '0;
        end else begin
          v_cnt_d   = v_cnt_q + 12'd1;
        end
        // Frame ends on the final line of vertical back porch
        if ((v_state_q == ST_BACK) && w_v_last) begin
          pos_y_d = '0;
        end else begin
          pos_y_d = pos_y_q + 12'd1;
        end
      end else begin
        pos_x_d = pos_x_q + 12'd1;
      end

      // Registered encoder-facing outputs for the current position
      if (w_active && pixel_valid) begin
        data0_d = pixel_data[7:0];
        data1_d = pixel_data[15:8];
        data2_d = pixel_data[23:16];
      end else begin
        // Blanking, or a starved active pixel, shows black
        data0_d = '0;
        data1_d = '0;
        data2_d = '0;
      end
      de_d    = w_active;
      ctrl0_d = {~((v_state_q == ST_SYNC) ^ c_POL),
                 ~((h_state_q == ST_SYNC) ^ c_POL)};
      fs_d    = (pos_x_q == 12'd0) && (pos_y_q == 12'd0);

      // A new underflow takes priority over a simultaneous clear
      if (w_active && !pixel_valid) begin
        uf_d = 1'b1;
      end else if (clear_underflow) begin
        uf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_state_q <= ST_ACTIVE;
      v_state_q <= ST_ACTIVE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      de_q      <= 1'b0;
      ctrl0_q   <= c_CTRL_IDLE;
      fs_q      <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      de_q      <= de_d;
      ctrl0_q   <= ctrl0_d;
      fs_q      <= fs_d;
      uf_q      <= uf_d;
    end
  end

  assign out_data0       = data0_q;
  assign out_data1       = data1_q;
  assign out_data2       = data2_q;
  assign out_data_enable = de_q;
  assign out_control0    = ctrl0_q;
  assign out_control1    = 2'b00;
  assign out_control2    = 2'b00;
  assign position_x      = pos_x_q;
  assign position_y      = pos_y_q;
  assign frame_start     = fs_q;
  assign underflow       = uf_q;

endmodule
`default_nettype wire

// File: tb/tb_ibis_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibis_video_timing
// Purpose  : Directed bench for ibis_video_timing using a reduced raster
//            (13 x 8 positions) so whole frames run quickly. Expected values
//            come from a position-based model of the raster.
// Revision : 1.0  initial release
// ============================================================================
module tb_ibis_video_timing;

  localparam int HA = 6, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 13
  localparam int VT = VA + VF + VS + VB;   // 8

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [23:0] pixel_data = '0;
  logic        clear_underflow = 1'b0;
  logic        pixel_ready;
  logic [7:0]  out_data0, out_data1, out_data2;
  logic        out_data_enable;
  logic [1:0]  out_control0, out_control1, out_control2;
  logic [11:0] position_x, position_y;
  logic        frame_start;
  logic        underflow;

  ibis_video_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POLARITY(0)
  ) u_dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .pixel_valid     (pixel_valid),
    .pixel_data      (pixel_data),
    .pixel_ready     (pixel_ready),
    .clear_underflow (clear_underflow),
    .out_data0       (out_data0),
    .out_data1       (out_data1),
    .out_data2       (out_data2),
    .out_data_enable (out_data_enable),
    .out_control0    (out_control0),
    .out_control1    (out_control1),
    .out_control2    (out_control2),
    .position_x      (position_x),
    .position_y      (position_y),
    .frame_start     (frame_start),
    .underflow       (underflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  // Raster model: current position and expected registered outputs
  int         mx, my;
  logic [7:0] e_d0, e_d1, e_d2;
  logic       e_de, e_fs, e_uf;
  logic [1:0] e_c0;

  // Observed-output tallies for whole-frame checks
  int obs_de, obs_hs, obs_vs, obs_fs, obs_rdy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0;
    e_d0 = '0; e_d1 = '0; e_d2 = '0;
    e_de = 1'b0; e_fs = 1'b0; e_uf = 1'b0;
    e_c0 = 2'b11;
  endtask

  task automatic check_regs();
    check_eq("out_data0", 32'(out_data0), 32'(e_d0));
    check_eq("out_data1", 32'(out_data1), 32'(e_d1));
    check_eq("out_data2", 32'(out_data2), 32'(e_d2));
    check_eq("data_enable", 32'(out_data_enable), 32'(e_de));
    check_eq("control0", 32'(out_control0), 32'(e_c0));
    check_eq("control1", 32'(out_control1), 32'd0);
    check_eq("control2", 32'(out_control2), 32'd0);
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
    check_eq("underflow", 32'(underflow), 32'(e_uf));
  endtask

  // One clock: drive inputs, check live signals mid-cycle, then check the
  // registered outputs just after the edge. Called at posedge + 1.
  task automatic tick(input logic en, input logic vld, input logic clr);
    logic        act, hs_a, vs_a;
    logic [23:0] pd;
    pd = {8'(mx * 7 + 3), 8'(my + 80), 8'(mx)};
    enable = en; pixel_valid = vld; clear_underflow = clr; pixel_data = pd;
    act  = (mx < HA) && (my < VA);
    hs_a = (mx >= HA + HF) && (mx < HA + HF + HS);
    vs_a = (my >= VA + VF) && (my < VA + VF + VS);
    @(negedge clock);
    check_eq("pixel_ready", 32'(pixel_ready), 32'(en && act));
    check_eq("position_x", 32'(position_x), 32'(mx));
    check_eq("position_y", 32'(position_y), 32'(my));
    if (pixel_ready) obs_rdy++;
    if (en) begin
      if (act && vld) begin
        e_d0 = pd[7:0]; e_d1 = pd[15:8]; e_d2 = pd[23:16];
      end else begin
        e_d0 = '0; e_d1 = '0; e_d2 = '0;
      end
      e_de = act;
      e_c0 = {~vs_a, ~hs_a};
      e_fs = (mx == 0) && (my == 0);
      if (act && !vld) e_uf = 1'b1;
      else if (clr)    e_uf = 1'b0;
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) my = 0;
      end
    end
    @(posedge clock);
    #1;
    check_regs();
    if (out_data_enable) obs_de++;
    if (!out_control0[0]) obs_hs++;
    if (!out_control0[1]) obs_vs++;
    if (frame_start) obs_fs++;
  endtask

  task automatic run_to(input int tx, input int ty);
    for (int i = 0; i < 4 * HT * VT && !(mx == tx && my == ty); i++) begin
      tick(1'b1, 1'b1, 1'b0);
    end
    check_eq("run_to_x", 32'(position_x), 32'(tx));
    check_eq("run_to_y", 32'(position_y), 32'(ty));
  endtask

  task automatic clear_tallies();
    obs_de = 0; obs_hs = 0; obs_vs = 0; obs_fs = 0; obs_rdy = 0;
  endtask

  initial begin
    // Reset state
    model_reset();
    clear_tallies();
    #12;
    check_regs();
    check_eq("reset_pos_x", 32'(position_x), 32'd0);
    check_eq("reset_pos_y", 32'(position_y), 32'd0);
    check_eq("reset_ready", 32'(pixel_ready), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // One full frame with enable and valid held high
    clear_tallies();
    for (int i = 0; i < HT * VT; i++) tick(1'b1, 1'b1, 1'b0);
    check_eq("frame_de_count", 32'(obs_de), 32'(HA * VA));
    check_eq("frame_hsync_count", 32'(obs_hs), 32'(HS * VT));
    check_eq("frame_vsync_count", 32'(obs_vs), 32'(VS * HT));
    check_eq("frame_fs_count", 32'(obs_fs), 32'd1);
    check_eq("frame_ready_count", 32'(obs_rdy), 32'(HA * VA));
    check_eq("frame_wrap_x", 32'(position_x), 32'd0);
    check_eq("frame_wrap_y", 32'(position_y), 32'd0);

    // Second frame: frame_start exactly once more
    clear_tallies();
    for (int i = 0; i < HT * VT; i++) tick(1'b1, 1'b1, 1'b0);
    check_eq("frame2_fs_count", 32'(obs_fs), 32'd1);
    check_eq("frame2_de_count", 32'(obs_de), 32'(HA * VA));

    // Three starved active pixels: black output, sticky underflow
    run_to(2, 1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
    check_eq("underflow_sticky", 32'(underflow), 32'd1);
    tick(1'b1, 1'b1, 1'b1);
    check_eq("underflow_cleared", 32'(underflow), 32'd0);
    // Missing pixel during blanking is not an underflow
    run_to(7, 1);
    tick(1'b1, 1'b0, 1'b0);
    check_eq("blank_no_underflow", 32'(underflow), 32'd0);
    // Underflow and clear together: set wins
    run_to(1, 2);
    tick(1'b1, 1'b0, 1'b1);
    check_eq("set_beats_clear", 32'(underflow), 32'd1);
    tick(1'b1, 1'b1, 1'b1);

    // Enable at 1-in-4 across a frame boundary
    run_to(0, VT - 1);
    clear_tallies();
    for (int i = 0; i < 4 * HT * 2; i++) tick((i % 4) == 0, 1'b1, 1'b0);
    check_eq("slow_fs_count", 32'(obs_fs), 32'd4);

    // Asynchronous reset mid-line
    run_to(4, 2);
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    check_eq("async_pos_x", 32'(position_x), 32'd0);
    check_eq("async_pos_y", 32'(position_y), 32'd0);
    @(posedge clock);
    #1;
    check_regs();
    reset = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    check_eq("post_reset_fs", 32'(frame_start), 32'd1);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ibis_video_timing.md
# ibis_video_timing

Raster timing controller that sequences the three `ibis_tmds_encoder` channels. It walks a programmable horizontal/vertical timing and pulls RGB pixels from an upstream source over a ready/valid handshake. Each pixel-clock-enable cycle it presents registered pixel data, data-enable and per-channel control symbols to the encoders. It sits between the frame/pixel source and the encoder/serializer stage, on the same clock and `enable` strobe as the encoders.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_POLARITY`, 0, 1 = syncs active-high, 0 = active-low
- `clock`  in  1  system clock; all logic on posedge
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `enable`  in  1  pixel-clock enable; all state advances only when high
- `pixel_valid`  in  1  upstream pixel available
- `pixel_data`  in  24  {red[23:16], green[15:8], blue[7:0]}
- `pixel_ready`  out  1  combinational: pixel consumed this cycle
- `clear_underflow`  in  1  clears sticky `underflow`
- `out_data0` / `out_data1` / `out_data2`  out  8 each  blue / green / red to encoder channels 0/1/2
- `out_data_enable`  out  1  active-video flag to all encoders
- `out_control0`  out  2  {vsync, hsync} to channel 0
- `out_control1`, `out_control2`  out  2 each  constant 2'b00
- `position_x`, `position_y`  out  12 each  current raster position (counter value, unregistered view)
- `frame_start`  out  1  one-enable-cycle pulse, registered
- `underflow`  out  1  sticky flag

## Operation
- Horizontal FSM states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Durations are H_ACTIVE/H_FRONT/H_SYNC/H_BACK enable cycles. An in-state counter resets to 0 on each transition.
- Vertical FSM has the same four states, in lines. It advances only on an enable cycle that is the last cycle of horizontal BACK.
- `position_x` counts 0..(H total − 1) and wraps to 0 at end of line. `position_y` counts 0..(V total − 1) and wraps at end of frame. Both are 12-bit; every total must be ≤ 4096. Larger totals are illegal and flagged by an elaboration-time assertion. All parameters ≥ 1.
- Active pixel: horizontal ACTIVE && vertical ACTIVE.
- `pixel_ready` = `enable` && active pixel.
  - If `pixel_ready` && `pixel_valid`: register `pixel_data` into `out_data0..2`.
  - If `pixel_ready` && !`pixel_valid`: register 0 (black) and set `underflow`.
- `underflow` clears on `clear_underflow`. If set and clear occur in the same cycle, set wins.
- Blanking cycles: `out_data0..2` <= 0.
- hsync asserted = horizontal SYNC. vsync asserted = vertical SYNC, for full lines. Drive level = asserted XNOR `SYNC_POLARITY`, i.e. deasserted = ~`SYNC_POLARITY`.
- `frame_start` <= 1 on the enable cycle at position (0,0), else 0 on the next enable cycle. It stays high across non-enable cycles.
- `reset` low (async, at any time, including mid-frame): FSMs -> ACTIVE/ACTIVE, counters and position -> 0, `underflow` 0. The next frame starts cleanly at (0,0) after release.

## Timing
- Reset values:
  - `out_data0..2` = 0, `out_data_enable` = 0, `frame_start` = 0, `underflow` = 0
  - `out_control0` = {~SYNC_POLARITY, ~SYNC_POLARITY}, `out_control1/2` = 0
  - `position_x`/`position_y` = 0
- Registered outputs update only on enable cycles and reflect the position of that cycle. Latency from position to outputs is one enable cycle.
- Registered outputs hold when `enable` is low. Counters and FSMs hold too.
- `pixel_ready` is never asserted during blanking or while `enable` is low.
- First enable cycle after reset release is position (0,0), active. `frame_start` rises at the end of that cycle.
- Frame period = (H total) × (V total) enable cycles; 800 × 525 = 420000 for the defaults.

## Test plan
- Reset, `enable` tied high, `pixel_valid` high, defaults → exactly 640 `out_data_enable` cycles per line and 480 active lines per frame; `frame_start` every 420000 cycles.
- Line timing → hsync low (SYNC_POLARITY=0) for 96 cycles starting 656 cycles after line start; vsync low for 2 lines starting at line 490; `out_control0` = 2'b11 elsewhere.
- `pixel_data` = incrementing x → `out_data0` = x[7:0] one cycle after `pixel_ready`; `pixel_ready` count per frame = 307200.
- Drop `pixel_valid` for 3 active cycles → 3 black pixels; `underflow` sets and stays set; `clear_underflow` pulse → 0. Simultaneous underflow + clear → stays 1.
- `enable` toggling 1-in-4 → same sequence stretched 4×, outputs stable between enables.
- Assert `reset` mid-line at position (300,200) → all outputs at reset values immediately (async); after release, first enable cycle is (0,0) and `frame_start` pulses.
